// File: rtl/cpu_mem_port.sv
// cpu_mem_port: turns one-cycle core read/write commands into held active-low OE/WE requests with timeout
module cpu_mem_port #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_busy,
  output logic              timeout_err,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  input  logic              memReady
);
  typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, RELEASE} state_t;
  state_t state, nxt;
  logic [15:0] cnt;
  logic tmo, req, accept;
  assign req = state == RD_REQ || state == WR_REQ;
  // counter holds cycles already spent; expiring on this edge means TIMEOUT cycles held
  assign tmo = cnt == 16'(TIMEOUT - 1);
  assign accept = state == IDLE && (cpu_read || cpu_write);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = cpu_write ? WR_REQ : cpu_read ? RD_REQ : IDLE;
      RELEASE: nxt = IDLE;
      default: nxt = (memReady || tmo) ? RELEASE : state;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      ADDR <= '0;
      Data_to_SRAM <= '0;
      cpu_rdata <= '0;
      timeout_err <= 1'b0;
      cnt <= '0;
    end else begin
      if (accept) begin
        ADDR <= cpu_addr;
        timeout_err <= 1'b0;
        cnt <= '0;
        if (cpu_write) Data_to_SRAM <= cpu_wdata;
      end
      if (req) begin
        cnt <= cnt + 16'd1;
        if (memReady && state == RD_REQ) cpu_rdata <= Data_from_SRAM;
        if (!memReady && tmo) timeout_err <= 1'b1;
      end
    end
  // all strobes decode only the state register, so nothing passes straight from inputs
  assign OE = state != RD_REQ;
  assign WE = state != WR_REQ;
  assign cpu_done = state == RELEASE;
  assign cpu_busy = state != IDLE;
endmodule
